// File: rtl/acquisition_sequencer.sv
// rtl/acquisition_sequencer.sv - pre/post-trigger acquisition and readout sequencer for the channel FIFOs
// ACQ_EARLY_TRIGGER_EN: a trigger during PRE_FILL jumps straight to POST with a shortened pre window.
module acquisition_sequencer #(
  parameter int g_Length_Width     = 10,
  parameter int g_FIFO_Depth       = 1024,
  parameter int g_Num_Of_TRG_Units = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Arm,
  input  logic                          Abort,
  input  logic [g_Length_Width-1:0]     Pre_Trigger_Samples,
  input  logic [g_Length_Width-1:0]     Post_Trigger_Samples,
  input  logic [g_Num_Of_TRG_Units-1:0] TRG_Detect_Vector,
  input  logic [g_Num_Of_TRG_Units-1:0] TRG_Enable_Vector,
  output logic                          Fifo_WE,
  output logic                          Fifo_RE,
  output logic                          Out_Valid,
  input  logic                          Out_Ready,
  output logic                          Out_Last,
  output logic                          Busy,
  output logic [2:0]                    State,
  output logic [15:0]                   Event_Count
);
  localparam int CW = $clog2(g_FIFO_Depth + 1);
  localparam int XW = ((CW > g_Length_Width) ? CW : g_Length_Width) + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE_FILL = 3'd1,
    S_WAIT_TRG = 3'd2,
    S_POST     = 3'd3,
    S_READOUT  = 3'd4,
    S_FLUSH    = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] pre_len, post_len, cnt, occupancy;
  logic [CW-1:0] pre_c, post_c;
  logic [XW-1:0] pre_x, post_x, post_room;
  logic          out_valid, out_last, busy;
  logic [15:0]   event_count;
  logic          trigger, we, re, accept_last;

  assign trigger     = |(TRG_Detect_Vector & TRG_Enable_Vector);
  assign accept_last = out_valid && Out_Ready && out_last;

  // Clamp so that pre + post always fits in one FIFO.
  always_comb begin
    pre_x = XW'(Pre_Trigger_Samples);
    if (pre_x > XW'(g_FIFO_Depth - 1)) pre_x = XW'(g_FIFO_Depth - 1);
    post_room = XW'(g_FIFO_Depth) - pre_x;
    post_x    = XW'(Post_Trigger_Samples);
    if (post_x > post_room) post_x = post_room;
    if (post_x == '0) post_x = XW'(1);
    pre_c  = CW'(pre_x);
    post_c = CW'(post_x);
  end

  always_comb begin
    state_next = state;
    we         = 1'b0;
    re         = 1'b0;
    case (state)
      S_IDLE: begin
        if (Arm) state_next = (pre_c == '0) ? S_WAIT_TRG : S_PRE_FILL;
      end
      S_PRE_FILL: begin
        we = 1'b1;
`ifdef ACQ_EARLY_TRIGGER_EN
        if (trigger) state_next = S_POST;
        else if (cnt == pre_len - CW'(1)) state_next = S_WAIT_TRG;
`else
        if (cnt == pre_len - CW'(1)) state_next = S_WAIT_TRG;
`endif
      end
      S_WAIT_TRG: begin
        // Sliding window: write the new sample and drop the oldest.
        we = (pre_len != '0);
        re = (pre_len != '0);
        if (trigger) state_next = S_POST;
      end
      S_POST: begin
        we = 1'b1;
        if (cnt == post_len - CW'(1)) state_next = S_READOUT;
      end
      S_READOUT: begin
        re = (occupancy != '0) && (!out_valid || Out_Ready);
        if (accept_last) state_next = S_IDLE;
      end
      S_FLUSH: begin
        re = (occupancy != '0);
        if (occupancy <= CW'(1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (Abort && state != S_IDLE) state_next = S_FLUSH;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      pre_len     <= '0;
      post_len    <= '0;
      cnt         <= '0;
      occupancy   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      event_count <= '0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != S_IDLE);
      occupancy <= occupancy + CW'(we) - CW'(re);
      if (state == S_IDLE && Arm) begin
        pre_len  <= pre_c;
        post_len <= post_c;
      end
      if (state_next != state || (state != S_PRE_FILL && state != S_POST)) cnt <= '0;
      else cnt <= cnt + CW'(1);
      // In READOUT the occupancy is exactly the number of words still to read.
      if (state == S_READOUT && state_next == S_READOUT) begin
        if (re) begin
          out_valid <= 1'b1;
          out_last  <= (occupancy == CW'(1));
        end else if (Out_Ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (state == S_READOUT && state_next == S_IDLE) event_count <= event_count + 16'd1;
    end
  end

  assign Fifo_WE     = we;
  assign Fifo_RE     = re;
  assign Out_Valid   = out_valid;
  assign Out_Last    = out_last;
  assign Busy        = busy;
  assign State       = state;
  assign Event_Count = event_count;
endmodule

// File: tb/tb_acquisition_sequencer.sv
// tb/tb_acquisition_sequencer.sv - randomized bench for acquisition_sequencer against a sample-window model
module tb_acquisition_sequencer;
  localparam int D = 1024;

  logic        Clock = 1'b0;
  logic        Reset, Arm, Abort, Out_Ready;
  logic [9:0]  Pre_Trigger_Samples, Post_Trigger_Samples;
  logic [7:0]  TRG_Detect_Vector, TRG_Enable_Vector;
  logic        Fifo_WE, Fifo_RE, Out_Valid, Out_Last, Busy;
  logic [2:0]  State;
  logic [15:0] Event_Count;

  acquisition_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Arm(Arm), .Abort(Abort),
    .Pre_Trigger_Samples(Pre_Trigger_Samples), .Post_Trigger_Samples(Post_Trigger_Samples),
    .TRG_Detect_Vector(TRG_Detect_Vector), .TRG_Enable_Vector(TRG_Enable_Vector),
    .Fifo_WE(Fifo_WE), .Fifo_RE(Fifo_RE), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Last(Out_Last), .Busy(Busy), .State(State), .Event_Count(Event_Count)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Channel FIFO model: each written word is the index of the cycle it was written in.
  int cyc = 0, arm_cyc = 0, q_reg = 0;
  int fifo_q[$];
  int acc_q[$];
  bit lastf_q[$];
  bit trig_hist[int];
  int we_cnt = 0, max_occ = 0, underflow = 0, re_stall = 0;
  int first_acc = 0, last_acc = 0;
  bit aborting = 1'b0;
  int occ_at_abort = 0, flush_re = 0, valid_after_abort = 0;
  int ev_model = 0;

  always @(negedge Clock) begin
    if (!Reset) begin
      trig_hist[cyc] = |(TRG_Detect_Vector & TRG_Enable_Vector);
      if (Arm) arm_cyc = cyc;
      if (!Busy) aborting = 1'b0;
      if (Out_Valid && !Out_Ready && Fifo_RE) re_stall++;
      if (aborting && Out_Valid) valid_after_abort++;
      if (aborting && Fifo_RE) flush_re++;
      if (Out_Valid && Out_Ready) begin
        if (acc_q.size() == 0) first_acc = cyc;
        last_acc = cyc;
        acc_q.push_back(q_reg);
        lastf_q.push_back(Out_Last);
      end
      if (Fifo_RE) begin
        if (fifo_q.size() == 0) underflow++;
        else q_reg = fifo_q.pop_front();
      end
      if (Fifo_WE) begin
        fifo_q.push_back(cyc);
        we_cnt++;
      end
      if (fifo_q.size() > max_occ) max_occ = fifo_q.size();
      if (Abort && Busy && !aborting) begin
        aborting     = 1'b1;
        occ_at_abort = fifo_q.size();
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // rmode: 0 ready held high, 1 ready toggling, 2 random ready.
  task automatic run_event(input string name, input int pre_i, input int post_i,
                           input int tdelay, input int rmode, input bit solid);
    int j, pre_c, post_c, start, t, first, last, n, bad, lp, nl;
    bit found;
    acc_q.delete();
    lastf_q.delete();
    we_cnt = 0;
    Pre_Trigger_Samples  = 10'(pre_i);
    Post_Trigger_Samples = 10'(post_i);
    TRG_Detect_Vector = '0;
    Arm = 1'b1;
    tick();
    Arm = 1'b0;
    j = 0;
    while (Busy && j < 6000) begin
      Pre_Trigger_Samples  = 10'($urandom);
      Post_Trigger_Samples = 10'($urandom);
      if (j >= tdelay) begin
        if (solid) begin
          TRG_Detect_Vector = 8'hFF;
          TRG_Enable_Vector = 8'hFF;
        end else begin
          TRG_Detect_Vector = 8'($urandom);
          TRG_Enable_Vector = 8'($urandom);
        end
      end else begin
        TRG_Detect_Vector = '0;
        TRG_Enable_Vector = 8'($urandom);
      end
      if (rmode == 0) Out_Ready = 1'b1;
      else if (rmode == 1) Out_Ready = (j % 2 == 0);
      else Out_Ready = ($urandom_range(0, 1) == 1);
      tick();
      j++;
    end
    TRG_Detect_Vector = '0;
    Out_Ready = 1'b0;
    check_eq($sformatf("%s_done", name), Busy, 0);

    pre_c  = (pre_i > D - 1) ? D - 1 : pre_i;
    post_c = (post_i > D - pre_c) ? D - pre_c : post_i;
    if (post_c == 0) post_c = 1;
`ifdef ACQ_EARLY_TRIGGER_EN
    start = arm_cyc + 1;
`else
    start = arm_cyc + pre_c + 1;
`endif
    found = 1'b0;
    t = start;
    while (t < cyc && !found) begin
      if (trig_hist.exists(t) && trig_hist[t]) found = 1'b1;
      else t++;
    end
    check_eq($sformatf("%s_trig_found", name), found, 1);
    if (found) begin
      first = (t - pre_c + 1 > arm_cyc + 1) ? t - pre_c + 1 : arm_cyc + 1;
      last  = t + post_c;
      n     = last - first + 1;
      check_eq($sformatf("%s_words", name), acc_q.size(), n);
      bad = 0;
      for (int i = 0; i < acc_q.size() && i < n; i++)
        if (acc_q[i] != first + i) bad++;
      check_eq($sformatf("%s_data_errs", name), bad, 0);
      lp = -1;
      nl = 0;
      for (int i = 0; i < lastf_q.size(); i++)
        if (lastf_q[i]) begin
          nl++;
          lp = i;
        end
      check_eq($sformatf("%s_last_pos", name), lp, n - 1);
      check_eq($sformatf("%s_last_cnt", name), nl, 1);
      check_eq($sformatf("%s_writes", name), we_cnt, last - ((pre_c == 0) ? t : arm_cyc));
      if (rmode == 0) check_eq($sformatf("%s_span", name), last_acc - first_acc + 1, n);
    end
    ev_model = (ev_model + 1) % 65536;
    check_eq($sformatf("%s_event_count", name), Event_Count, ev_model);
    check_eq($sformatf("%s_state", name), State, 0);
    check_eq($sformatf("%s_fifo_empty", name), fifo_q.size(), 0);
  endtask

  // exp_flush < 0 means compare against the model occupancy at the abort.
  task automatic run_abort(input string name, input int pre_i, input int post_i,
                           input int adelay, input bit solid, input int exp_flush);
    int j;
    acc_q.delete();
    lastf_q.delete();
    flush_re = 0;
    valid_after_abort = 0;
    occ_at_abort = -1;
    Pre_Trigger_Samples  = 10'(pre_i);
    Post_Trigger_Samples = 10'(post_i);
    Arm = 1'b1;
    tick();
    Arm = 1'b0;
    j = 0;
    while (Busy && j < 6000) begin
      TRG_Detect_Vector = solid ? 8'hFF : 8'($urandom);
      TRG_Enable_Vector = solid ? 8'hFF : 8'($urandom);
      Out_Ready = ($urandom_range(0, 1) == 1);
      Abort = (j == adelay);
      tick();
      j++;
    end
    Abort = 1'b0;
    TRG_Detect_Vector = '0;
    Out_Ready = 1'b0;
    check_eq($sformatf("%s_done", name), Busy, 0);
    check_eq($sformatf("%s_abort_seen", name), occ_at_abort >= 0, 1);
    check_eq($sformatf("%s_flush_re", name), flush_re, (exp_flush >= 0) ? exp_flush : occ_at_abort);
    check_eq($sformatf("%s_fifo_empty", name), fifo_q.size(), 0);
    check_eq($sformatf("%s_valid_after_abort", name), valid_after_abort, 0);
    check_eq($sformatf("%s_event_count", name), Event_Count, ev_model);
    check_eq($sformatf("%s_state", name), State, 0);
  endtask

  initial begin
    int p, q;
    Reset = 1'b1;
    Arm = 1'b0;
    Abort = 1'b0;
    Out_Ready = 1'b0;
    Pre_Trigger_Samples = '0;
    Post_Trigger_Samples = '0;
    TRG_Detect_Vector = '0;
    TRG_Enable_Vector = '0;
    repeat (3) tick();
    check_eq("rst_state", State, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_valid", Out_Valid, 0);
    check_eq("rst_last", Out_Last, 0);
    check_eq("rst_we_re", {Fifo_WE, Fifo_RE}, 0);
    check_eq("rst_evcnt", Event_Count, 0);
    Reset = 1'b0;
    tick();

    run_event("pre4_post6", 4, 6, 19, 0, 1'b1);
    run_event("pre0_post0", 0, 0, 0, 0, 1'b1);
    run_event("pre3_post3_toggle", 3, 3, 4, 1, 1'b1);
    run_abort("abort_post", 0, 10, 5, 1'b1, 5);
    run_event("pre1000_post100", 1000, 100, 3, 0, 1'b1);
    run_event("pre8_early", 8, 5, 1, 0, 1'b1);
    run_event("pre1023_post1023", 1023, 1023, 0, 2, 1'b1);
    run_abort("abort_readout", 3, 3, 9, 1'b1, -1);

    for (int k = 0; k < 12; k++) begin
      run_event($sformatf("rnd%0d", k), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 30), $urandom_range(0, 2), 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      p = $urandom_range(0, 10);
      q = $urandom_range(1, 10);
      run_abort($sformatf("rnd_abort%0d", k), p, q, $urandom_range(0, p + q - 1), 1'b0, -1);
    end

    check_eq("underflow", underflow, 0);
    check_eq("re_while_stalled", re_stall, 0);
    check_eq("occ_max", max_occ, D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
